fp_mul_seq_ctrl: RTL and testbench
==================================

Name: fp_mul_seq_ctrl

Overview:
Sequencing controller for the FP32 multiplier datapath. It accepts one operand pair through a valid/ready handshake and classifies both operands. Zero, subnormal, Inf and NaN cases are short-circuited to a final result. All other cases run an iterative Booth radix-4 mantissa multiply over several cycles. Its output (sign, unrounded exponent, 48-bit mantissa product, or a final special result) feeds the downstream normalize/round stage through a second valid/ready handshake.

Parameters:
DPC, 1, Booth digits retired per RUN cycle; legal range 1..13.
ITER, ceil(13/DPC), derived localparam: number of RUN cycles (13 for DPC=1).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any operation in flight
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept (high only in IDLE)
fp_X  in  32  operand X, IEEE-754 single
fp_Y  in  32  operand Y, IEEE-754 single
out_valid  out  1  result valid (high only in DONE)
out_ready  in  1  downstream accepts result
out_special  out  1  1: out_z is final; 0: out_sign/out_exp/out_mant are valid
out_z  out  32  final result for special cases
out_sign  out  1  sign of X XOR sign of Y
out_exp  out  10  signed, eX+eY-127 (range -125..381)
out_mant  out  48  exact {1,fX}*{1,fY}
busy  out  1  state != IDLE

Behaviour:
- One clock domain, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0. Also out_special=0, out_z=0, out_sign=0, out_exp=0, out_mant=0, and the iteration counter=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the operands are registered and classified.
- Classification per operand: sub = exponent==0 (covers zero; subnormals are flushed to zero), inf = exp==FF && frac==0, nan = exp==FF && frac!=0.
- Special results, in priority order:
  - any NaN, or inf paired with sub → out_z=0x7FC00000.
  - any inf → {s,0xFF,23'b0}.
  - any sub → {s,31'b0}, where s=sign X XOR sign Y.
- Special case: go to DONE with out_special=1; out_mant=0 and out_exp=0.
- Normal case: go to RUN with counter=0 and accumulator=0.
  - The multiplicand is mX={1,fX}.
  - The multiplier is the 27-bit {2'b00,1,fY,1'b0}. Digit k is taken from bits [2k+2:2k], k=0..12.
  - Digit decode: 000/111→0, 001/010→+mX, 011→+2mX, 100→-2mX, 101/110→-mX.
  - Each partial product is shifted left by 2k. Accumulate in at least 50-bit two's complement, truncated to 48 bits at the end.
- RUN: each cycle retires digits counter*DPC .. min(counter*DPC+DPC,13)-1 and increments the counter. On the cycle retiring digit 12, go to DONE with out_mant=final accumulator and out_special=0.
- Timing: acceptance in cycle c → special result: out_valid in cycle c+1. Normal: RUN cycles c+1..c+ITER, out_valid in cycle c+ITER+1.
- DONE: out_valid=1 and all out_* held stable until out_valid&&out_ready, then go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- flush=1 in any state: next state IDLE, out_valid=0, and the accumulator is discarded. flush takes priority over the in_valid and out_ready handshakes in the same cycle.
- in_valid while busy is ignored; operands are not sampled.
- fp_X/fp_Y changing after acceptance has no effect.
- Exponent: out_exp = eX + eY - 127, computed in 10-bit signed. No clamping: overflow and underflow are handled downstream.
- Async reset mid-RUN or mid-DONE: immediately return to reset values. No partial result is emitted.

Test Plan:
- 0x3F800000 × 0x3F800000, DPC=1 → out_valid exactly 14 cycles after accept. out_special=0, out_sign=0, out_exp=127, out_mant=0x400000000000.
- 0x40400000 × 0x40A00000 (3×5) → out_sign=0, out_exp=130, out_mant=0x780000000000. Repeat with DPC=13: out_valid 2 cycles after accept, same values.
- 0xC0000000 × 0x3F000000 (-2×0.5) → out_sign=1, out_exp=127, out_mant=0x400000000000.
- Special cases, each with out_valid 1 cycle after accept and out_special=1:
  - 0x7F800000 × 0x00000000 → out_z=0x7FC00000.
  - 0xFF800000 × 0x40000000 → out_z=0xFF800000.
  - 0x00000001 × 0xC0000000 → out_z=0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_* stable, in_ready=0, in_valid pulses ignored. Then raise out_ready=1 → IDLE next cycle, in_ready=1.
- flush in the 4th RUN cycle → IDLE next cycle, out_valid never asserts. Also assert rst_n low mid-RUN → all outputs at reset values immediately. Then a new 1.0×1.0 completes correctly.

Source files
------------

// File: rtl/fp_mul_seq_ctrl.sv
// FP32 multiplier sequencing controller: operand classification, special-case short-circuit and
// an iterative Booth radix-4 mantissa multiply feeding the normalize/round stage.
module fp_mul_seq_ctrl #(
    parameter int unsigned DPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_special,
    output logic [31:0] out_z,
    output logic        out_sign,
    output logic [9:0]  out_exp,
    output logic [47:0] out_mant,
    output logic        busy
);

    localparam int unsigned ITER = (13 + DPC - 1) / DPC;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [49:0] acc_q, acc_next;
    logic [23:0] mx_q;
    logic [26:0] my_q;

    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic        sub_x, sub_y, inf_x, inf_y, nan_x, nan_y;
    logic        is_special, sign_xy, last;
    logic [31:0] special_z;
    logic [9:0]  exp_sum;

    assign ex      = fp_X[30:23];
    assign ey      = fp_Y[30:23];
    assign fx      = fp_X[22:0];
    assign fy      = fp_Y[22:0];
    assign sub_x   = (ex == 8'h00);
    assign sub_y   = (ey == 8'h00);
    assign inf_x   = (ex == 8'hFF) && (fx == 23'd0);
    assign inf_y   = (ey == 8'hFF) && (fy == 23'd0);
    assign nan_x   = (ex == 8'hFF) && (fx != 23'd0);
    assign nan_y   = (ey == 8'hFF) && (fy != 23'd0);
    assign sign_xy = fp_X[31] ^ fp_Y[31];
    assign exp_sum = {2'b00, ex} + {2'b00, ey} - 10'd127;

    assign is_special = sub_x | sub_y | inf_x | inf_y | nan_x | nan_y;

    always_comb begin
        special_z = {sign_xy, 31'd0};
        if (nan_x || nan_y || (inf_x && sub_y) || (inf_y && sub_x)) begin
            special_z = 32'h7FC0_0000;
        end else if (inf_x || inf_y) begin
            special_z = {sign_xy, 8'hFF, 23'd0};
        end
    end

    assign last = (cnt_q == 4'(ITER - 1));

    // Retire up to DPC Booth digits this cycle; digit k weighs 4^k.
    int          k;
    logic [2:0]  digit;
    logic [49:0] mx_ext, pp;

    always_comb begin
        acc_next = acc_q;
        k        = 0;
        digit    = 3'b000;
        pp       = '0;
        mx_ext   = {26'd0, mx_q};
        for (int j = 0; j < int'(DPC); j++) begin
            k = int'(cnt_q) * int'(DPC) + j;
            if (k < 13) begin
                digit = 3'(my_q >> (2 * k));
                case (digit)
                    3'b001, 3'b010: pp = mx_ext;
                    3'b011:         pp = mx_ext << 1;
                    3'b100:         pp = -(mx_ext << 1);
                    3'b101, 3'b110: pp = -mx_ext;
                    default:        pp = '0;
                endcase
                acc_next = acc_next + (pp << (2 * k));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = is_special ? StDone : StRun;
            StRun:  if (last) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            out_special <= 1'b0;
            out_z       <= '0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_mant    <= '0;
        end else if (flush) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mx_q     <= {1'b1, fx};
                        my_q     <= {2'b00, 1'b1, fy, 1'b0};
                        out_sign <= sign_xy;
                        out_mant <= '0;
                        if (is_special) begin
                            out_special <= 1'b1;
                            out_z       <= special_z;
                            out_exp     <= '0;
                        end else begin
                            out_special <= 1'b0;
                            out_z       <= '0;
                            out_exp     <= exp_sum;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 4'd1;
                    if (last) out_mant <= acc_next[47:0];
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed bench for fp_mul_seq_ctrl with a scoreboard of expected results (DPC=1 and DPC=13).
module tb_fp_mul_seq_ctrl;

    typedef struct {
        logic        special;
        logic [31:0] z;
        logic        sign;
        logic [9:0]  e;
        logic [47:0] m;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_valid2, out_ready, sel;
    logic [31:0] fp_X, fp_Y;

    logic        in_ready_a, out_valid_a, out_special_a, out_sign_a, busy_a;
    logic [31:0] out_z_a;
    logic [9:0]  out_exp_a;
    logic [47:0] out_mant_a;
    logic        in_ready_b, out_valid_b, out_special_b, out_sign_b, busy_b;
    logic [31:0] out_z_b;
    logic [9:0]  out_exp_b;
    logic [47:0] out_mant_b;

    logic        o_in_ready, o_out_valid, o_special, o_sign, o_busy;
    logic [31:0] o_z;
    logic [9:0]  o_exp;
    logic [47:0] o_mant;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    fp_mul_seq_ctrl #(.DPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .fp_X(fp_X), .fp_Y(fp_Y), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_special(out_special_a), .out_z(out_z_a), .out_sign(out_sign_a),
        .out_exp(out_exp_a), .out_mant(out_mant_a), .busy(busy_a)
    );

    fp_mul_seq_ctrl #(.DPC(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready_b),
        .fp_X(fp_X), .fp_Y(fp_Y), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_special(out_special_b), .out_z(out_z_b), .out_sign(out_sign_b),
        .out_exp(out_exp_b), .out_mant(out_mant_b), .busy(busy_b)
    );

    assign o_in_ready  = sel ? in_ready_b    : in_ready_a;
    assign o_out_valid = sel ? out_valid_b   : out_valid_a;
    assign o_special   = sel ? out_special_b : out_special_a;
    assign o_sign      = sel ? out_sign_b    : out_sign_a;
    assign o_busy      = sel ? busy_b        : busy_a;
    assign o_z         = sel ? out_z_b       : out_z_a;
    assign o_exp       = sel ? out_exp_b     : out_exp_a;
    assign o_mant      = sel ? out_mant_b    : out_mant_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit wide);
        exp_t r;
        logic [7:0] ex, ey;
        logic       sx, sy, ix, iy, nx, ny, s;
        ex = x[30:23];
        ey = y[30:23];
        sx = (ex == 0);
        sy = (ey == 0);
        ix = (ex == 8'hFF) && (x[22:0] == 0);
        iy = (ey == 8'hFF) && (y[22:0] == 0);
        nx = (ex == 8'hFF) && (x[22:0] != 0);
        ny = (ey == 8'hFF) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        r.sign = s;
        r.special = sx | sy | ix | iy | nx | ny;
        r.z = '0;
        r.e = '0;
        r.m = '0;
        if (nx || ny || (ix && sy) || (iy && sx)) r.z = 32'h7FC0_0000;
        else if (ix || iy)                        r.z = {s, 8'hFF, 23'd0};
        else if (sx || sy)                        r.z = {s, 31'd0};
        else begin
            r.e = 10'(ex) + 10'(ey) - 10'd127;
            r.m = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        end
        r.lat = r.special ? 1 : (wide ? 2 : 14);
        return r;
    endfunction

    task automatic accept(input bit s, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        sel = s;
        @(negedge clk);
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", {63'd0, o_in_ready}, 64'd1);
        fp_X = x;
        fp_Y = y;
        if (s) in_valid2 = 1'b1;
        else   in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        fp_X = $urandom;
        fp_Y = $urandom;
    endtask

    task automatic get_result(input int hold);
        int   lat = 1;
        exp_t e;
        @(negedge clk);
        while (!o_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            chk("latency", 64'(lat), 64'(e.lat));
            chk("out_special", {63'd0, o_special}, {63'd0, e.special});
            chk("out_sign", {63'd0, o_sign}, {63'd0, e.sign});
            chk("out_exp", {54'd0, o_exp}, {54'd0, e.e});
            chk("out_mant", {16'd0, o_mant}, {16'd0, e.m});
            if (e.special) chk("out_z", {32'd0, o_z}, {32'd0, e.z});
            for (int i = 0; i < hold; i++) begin
                in_valid = (i % 2 == 0);
                fp_X = $urandom;
                fp_Y = $urandom;
                @(negedge clk);
                chk("hold_out_valid", {63'd0, o_out_valid}, 64'd1);
                chk("hold_in_ready", {63'd0, o_in_ready}, 64'd0);
                chk("hold_out_mant", {16'd0, o_mant}, {16'd0, e.m});
                chk("hold_out_exp", {54'd0, o_exp}, {54'd0, e.e});
                chk("hold_out_sign", {63'd0, o_sign}, {63'd0, e.sign});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, o_in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, o_out_valid}, 64'd0);
    endtask

    task automatic op(input bit s, input logic [31:0] x, input logic [31:0] y, input int hold);
        sbq.push_back(model(x, y, s));
        accept(s, x, y);
        get_result(hold);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready_a}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, out_valid_a}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_a}, 64'd0);
        chk({tag, "_special"}, {63'd0, out_special_a}, 64'd0);
        chk({tag, "_z"}, {32'd0, out_z_a}, 64'd0);
        chk({tag, "_sign"}, {63'd0, out_sign_a}, 64'd0);
        chk({tag, "_exp"}, {54'd0, out_exp_a}, 64'd0);
        chk({tag, "_mant"}, {16'd0, out_mant_a}, 64'd0);
    endtask

    initial begin
        int seen = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b0; sel = 1'b0; fp_X = '0; fp_Y = '0;
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 0);
        op(1'b0, 32'h4040_0000, 32'h40A0_0000, 0);
        op(1'b1, 32'h4040_0000, 32'h40A0_0000, 0);
        op(1'b0, 32'hC000_0000, 32'h3F00_0000, 0);
        op(1'b0, 32'h7F80_0000, 32'h0000_0000, 0);
        op(1'b0, 32'hFF80_0000, 32'h4000_0000, 0);
        op(1'b0, 32'h0000_0001, 32'hC000_0000, 0);
        op(1'b0, 32'h7FC0_1234, 32'h3F80_0000, 0);
        op(1'b1, 32'hBFFF_FFFF, 32'h7F7F_FFFF, 0);
        op(1'b0, 32'h3FFF_FFFF, 32'hBFFF_FFFF, 0);
        // Backpressure with in_valid pulses while DONE is held.
        op(1'b0, 32'h4040_0000, 32'h40A0_0000, 5);
        @(negedge clk);
        chk("no_accept_after_hold", {63'd0, busy_a}, 64'd0);

        // Flush in the 4th RUN cycle.
        accept(1'b0, 32'h3F80_0000, 32'h3F80_0000);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("flush_busy", {63'd0, busy_a}, 64'd0);
        repeat (20) begin
            @(negedge clk);
            if (out_valid_a) seen++;
        end
        chk("flush_no_out_valid", 64'(seen), 64'd0);

        // Async reset mid-RUN.
        accept(1'b0, 32'h4040_0000, 32'h40A0_0000);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
